// File: rtl/video_picture_overlay.sv
// Picture-over-background overlay with per-frame origin, power-of-two upscale and colour key.
// Define OVERLAY_BOUNCE_EN to let the origin bounce off the display edges every frame.
module video_picture_overlay #(
    parameter int          CW         = 11,
    parameter int          H_DISP     = 1920,
    parameter int          V_DISP     = 1080,
    parameter int          PIC_W      = 200,
    parameter int          PIC_H      = 200,
    parameter int          AW         = 16,
    parameter int          ROM_LAT    = 1,
    parameter logic [23:0] BACK_COLOR = 24'hE0FFFF,
    parameter int          X_INIT     = 10,
    parameter int          Y_INIT     = 10,
    parameter int          STEP       = 2
) (
    input  logic          pixel_clk,
    input  logic          sys_rst,
    input  logic [CW-1:0] pixel_xpos,
    input  logic [CW-1:0] pixel_ypos,
    input  logic          frame_start,
    input  logic [CW-1:0] pos_x,
    input  logic [CW-1:0] pos_y,
    input  logic          pos_load,
    input  logic [1:0]    scale_shift,
    input  logic          key_en,
    input  logic [23:0]   key_color,
    output logic [AW-1:0] rom_addr,
    input  logic [23:0]   rom_rd_data,
    output logic [23:0]   pixel_data,
    output logic          pic_active
);

    localparam int XW = CW + 3;
    localparam logic [XW-1:0] PW  = XW'(PIC_W);
    localparam logic [XW-1:0] PH  = XW'(PIC_H);
    localparam logic [XW-1:0] HD  = XW'(H_DISP);
    localparam logic [XW-1:0] VD  = XW'(V_DISP);
    localparam logic [AW-1:0] PWA = AW'(PIC_W);

    logic [CW-1:0] org_x, org_y, org_x_n, org_y_n;
    logic [CW-1:0] pend_x, pend_y;
    logic          pend;
    logic [1:0]    scl;

    logic [XW-1:0] xe, ye, oxe, oye, sw, sh, rel_x, rel_y;
    logic          in_win;

    logic          s1_in;
    logic [AW-1:0] s1_col, s1_row;
    logic [ROM_LAT:0] win_sr;
    logic          keyed;

    assign xe    = XW'(pixel_xpos);
    assign ye    = XW'(pixel_ypos);
    assign oxe   = XW'(org_x);
    assign oye   = XW'(org_y);
    assign sw    = PW << scl;
    assign sh    = PH << scl;
    assign rel_x = xe - oxe;
    assign rel_y = ye - oye;

    assign in_win = (xe >= oxe) && (xe < oxe + sw) &&
                    (ye >= oye) && (ye < oye + sh) &&
                    (xe < HD) && (ye < VD);

`ifdef OVERLAY_BOUNCE_EN
    localparam logic [XW-1:0] ST = XW'(STEP);

    logic          dir_x, dir_y, dir_x_n, dir_y_n;
    logic          bdir_x, bdir_y;
    logic [XW-1:0] bnc_x, bnc_y;

    // Reflect once the next step would reach the far edge; neg=1 moves toward 0.
    function automatic logic [XW:0] bounce_axis(
        input logic [XW-1:0] o,
        input logic [XW-1:0] sz,
        input logic [XW-1:0] disp,
        input logic          neg
    );
        logic [XW-1:0] lim;
        logic [XW-1:0] r;
        logic          d;
        lim = (sz > disp) ? {XW{1'b0}} : disp - sz;
        d   = neg;
        r   = o;
        if (!neg) begin
            if (o + sz + ST >= disp) begin
                d = 1'b1;
                if (o > lim)
                    r = lim;
                else if (o >= ST)
                    r = o - ST;
                else
                    r = {XW{1'b0}};
            end else begin
                r = o + ST;
            end
        end else if (o < ST) begin
            d = 1'b0;
            r = {XW{1'b0}};
        end else begin
            r = o - ST;
        end
        return {d, r};
    endfunction

    always_comb begin
        {bdir_x, bnc_x} = bounce_axis(oxe, sw, HD, dir_x);
        {bdir_y, bnc_y} = bounce_axis(oye, sh, VD, dir_y);
    end
`endif

    always_comb begin
        org_x_n = org_x;
        org_y_n = org_y;
`ifdef OVERLAY_BOUNCE_EN
        dir_x_n = dir_x;
        dir_y_n = dir_y;
`endif
        if (frame_start) begin
            if (pos_load) begin
                org_x_n = pos_x;
                org_y_n = pos_y;
            end else if (pend) begin
                org_x_n = pend_x;
                org_y_n = pend_y;
            end
`ifdef OVERLAY_BOUNCE_EN
            else begin
                org_x_n = bnc_x[CW-1:0];
                org_y_n = bnc_y[CW-1:0];
                dir_x_n = bdir_x;
                dir_y_n = bdir_y;
            end
`endif
        end
    end

    // Geometry only changes at frame_start so a frame is never torn.
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            org_x  <= CW'(X_INIT);
            org_y  <= CW'(Y_INIT);
            pend_x <= '0;
            pend_y <= '0;
            pend   <= 1'b0;
            scl    <= 2'd0;
`ifdef OVERLAY_BOUNCE_EN
            dir_x  <= 1'b0;
            dir_y  <= 1'b0;
`endif
        end else begin
            org_x <= org_x_n;
            org_y <= org_y_n;
`ifdef OVERLAY_BOUNCE_EN
            dir_x <= dir_x_n;
            dir_y <= dir_y_n;
`endif
            if (frame_start) begin
                pend <= 1'b0;
                scl  <= (scale_shift == 2'd3) ? 2'd2 : scale_shift;
            end else if (pos_load) begin
                pend   <= 1'b1;
                pend_x <= pos_x;
                pend_y <= pos_y;
            end
        end
    end

    assign keyed = key_en && (rom_rd_data == key_color);

    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1_in      <= 1'b0;
            s1_col     <= '0;
            s1_row     <= '0;
            rom_addr   <= '0;
            win_sr     <= '0;
            pixel_data <= BACK_COLOR;
            pic_active <= 1'b0;
        end else begin
            s1_in  <= in_win;
            s1_col <= AW'(rel_x >> scl);
            s1_row <= AW'(rel_y >> scl);
            if (s1_in)
                rom_addr <= s1_row * PWA + s1_col;
            // win_sr[ROM_LAT] lines up with the ROM word for the same pixel.
            win_sr <= {win_sr[ROM_LAT-1:0], s1_in};
            if (win_sr[ROM_LAT] && !keyed) begin
                pixel_data <= rom_rd_data;
                pic_active <= 1'b1;
            end else begin
                pixel_data <= BACK_COLOR;
                pic_active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_video_picture_overlay.sv
// Randomised check of video_picture_overlay against a frame-level reference model.
module tb_video_picture_overlay;

    localparam int          CW    = 11;
    localparam int          H     = 1920;
    localparam int          V     = 1080;
    localparam int          PIC_W = 200;
    localparam int          PIC_H = 200;
    localparam int          AW    = 16;
    localparam int          NW    = PIC_W * PIC_H;
    localparam logic [23:0] BG    = 24'hE0FFFF;

    logic          pixel_clk;
    logic          sys_rst;
    logic [CW-1:0] pixel_xpos, pixel_ypos;
    logic          frame_start;
    logic [CW-1:0] pos_x, pos_y;
    logic          pos_load;
    logic [1:0]    scale_shift;
    logic          key_en;
    logic [23:0]   key_color;
    logic [AW-1:0] rom_addr;
    logic [23:0]   rom_rd_data;
    logic [23:0]   pixel_data;
    logic          pic_active;

    video_picture_overlay #(
        .CW(CW), .H_DISP(H), .V_DISP(V), .PIC_W(PIC_W), .PIC_H(PIC_H),
        .AW(AW), .ROM_LAT(1), .BACK_COLOR(BG), .X_INIT(10), .Y_INIT(10),
        .STEP(2)
    ) dut (
        .pixel_clk  (pixel_clk),
        .sys_rst    (sys_rst),
        .pixel_xpos (pixel_xpos),
        .pixel_ypos (pixel_ypos),
        .frame_start(frame_start),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .pos_load   (pos_load),
        .scale_shift(scale_shift),
        .key_en     (key_en),
        .key_color  (key_color),
        .rom_addr   (rom_addr),
        .rom_rd_data(rom_rd_data),
        .pixel_data (pixel_data),
        .pic_active (pic_active)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    logic [23:0] mem [NW];
    always @(posedge pixel_clk) rom_rd_data <= mem[int'(rom_addr) % NW];

    typedef struct {
        bit in;
        int addr;
    } exp_t;

    exp_t eq[$];
    int   aq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    int m_ox, m_oy, m_px, m_py, m_s, m_hold;
    bit m_pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h want %h", tag, $time, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        exp_t        e;
        logic [23:0] word;
        logic [23:0] want_pix;
        bit          want_act;
        if (eq.size() >= 4) begin
            e        = eq.pop_front();
            word     = e.in ? mem[e.addr] : BG;
            want_act = e.in && !(key_en && word == key_color);
            want_pix = want_act ? word : BG;
            chk({tag, "_pix"}, 32'(pixel_data), 32'(want_pix));
            chk({tag, "_act"}, 32'(pic_active), 32'(want_act));
        end
        if (aq.size() >= 2)
            chk({tag, "_addr"}, 32'(rom_addr), 32'(aq.pop_front()));
    endtask

    task automatic model_push(input int x, input int y);
        exp_t e;
        int   sw, sh;
        sw     = PIC_W << m_s;
        sh     = PIC_H << m_s;
        e.in   = (x >= m_ox) && (x < m_ox + sw) && (y >= m_oy) &&
                 (y < m_oy + sh) && (x < H) && (y < V);
        e.addr = 0;
        if (e.in) begin
            e.addr = ((y - m_oy) >> m_s) * PIC_W + ((x - m_ox) >> m_s);
            m_hold = e.addr;
        end
        eq.push_back(e);
        aq.push_back(m_hold);
    endtask

    task automatic step(input string tag, input int x, input int y,
                        input bit fs = 0, input bit pl = 0,
                        input int px = 0, input int py = 0, input int sc = 0);
        @(posedge pixel_clk);
        #1;
        check_outputs(tag);
        pixel_xpos  = CW'(x);
        pixel_ypos  = CW'(y);
        frame_start = fs;
        pos_load    = pl;
        pos_x       = CW'(px);
        pos_y       = CW'(py);
        scale_shift = 2'(sc);
        model_push(x, y);
        if (fs) begin
            if (pl) begin
                m_ox = px;
                m_oy = py;
            end else if (m_pend) begin
                m_ox = m_px;
                m_oy = m_py;
            end
            m_s    = (sc == 3) ? 2 : sc;
            m_pend = 0;
        end else if (pl) begin
            m_px   = px;
            m_py   = py;
            m_pend = 1;
        end
    endtask

    task automatic do_reset();
        exp_t bg_e;
        @(posedge pixel_clk);
        #3;
        sys_rst     = 1'b1;
        pixel_xpos  = '0;
        pixel_ypos  = '0;
        frame_start = 1'b0;
        pos_load    = 1'b0;
        #1;
        chk("rst_pix", 32'(pixel_data), 32'(BG));
        chk("rst_act", 32'(pic_active), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        repeat (2) @(posedge pixel_clk);
        #1;
        sys_rst = 1'b0;
        m_ox = 10;
        m_oy = 10;
        m_s = 0;
        m_pend = 0;
        m_hold = 0;
        eq.delete();
        aq.delete();
        bg_e.in   = 0;
        bg_e.addr = 0;
        repeat (3) eq.push_back(bg_e);
        aq.push_back(0);
        model_push(0, 0);
    endtask

    function automatic int near_x();
        int lo, hi;
        lo = (m_ox - 8 < 0) ? 0 : m_ox - 8;
        hi = m_ox + (PIC_W << m_s) + 8;
        if (hi > 2047) hi = 2047;
        return ($urandom_range(9, 0) < 8) ? int'($urandom_range(hi, lo))
                                          : int'($urandom_range(2047, 0));
    endfunction

    function automatic int near_y();
        int lo, hi;
        lo = (m_oy - 8 < 0) ? 0 : m_oy - 8;
        hi = m_oy + (PIC_H << m_s) + 8;
        if (hi > 2047) hi = 2047;
        return ($urandom_range(9, 0) < 8) ? int'($urandom_range(hi, lo))
                                          : int'($urandom_range(2047, 0));
    endfunction

    task automatic rand_steps(input int n, input bit allow_load);
        for (int i = 0; i < n; i++) begin
            if (allow_load && $urandom_range(49, 0) == 0)
                step("rnd_ld", near_x(), near_y(), 0, 1,
                     $urandom_range(1900, 0), $urandom_range(1070, 0));
            else
                step("rnd", near_x(), near_y());
        end
    endtask

    initial begin
        for (int i = 0; i < NW; i++) mem[i] = 24'(i);
        mem[5] = 24'h00FF00;
        sys_rst = 1'b1;
        pixel_xpos = '0;
        pixel_ypos = '0;
        frame_start = 1'b0;
        pos_x = '0;
        pos_y = '0;
        pos_load = 1'b0;
        scale_shift = 2'd0;
        key_en = 1'b0;
        key_color = 24'h00FF00;
        do_reset();

        step("a0", 10, 10);
        step("a1", 209, 10);
        step("a2", 210, 10);
        step("a3", 10, 11);
        step("a4", 209, 209);
        step("a5", 10, 210);
        step("a6", 9, 10);
        step("key_off", 15, 10);
        repeat (4) step("idle", 0, 0);
        key_en = 1'b1;
        step("key_on", 15, 10);
        step("key_near", 16, 10);
        repeat (4) step("idle", 0, 0);
        key_en = 1'b0;
        rand_steps(150, 0);

        step("fs_s1", 0, 0, 1, 0, 0, 0, 1);
        step("s1_a", 10, 10);
        step("s1_b", 11, 10);
        step("s1_c", 12, 10);
        step("s1_d", 409, 409);
        step("s1_e", 410, 10);
        step("s1_f", 10, 410);
        rand_steps(150, 0);

        step("fs_s3", 0, 0, 1, 0, 0, 0, 3);
        rand_steps(100, 0);

        step("fs_s0", 0, 0, 1, 0, 0, 0, 0);
        step("ld_mid", 20, 20, 0, 1, 500, 300);
        step("ld_keep", 10, 10);
        step("ld_keep2", 500, 300);
        step("fs_apply", 0, 0, 1, 0, 0, 0, 0);
        step("ld_new", 500, 300);
        step("ld_old", 10, 10);
        step("ld_new2", 699, 499);

        step("fs_coin", 0, 0, 1, 1, 1800, 1000, 1);
        step("edge_a", 1800, 1000);
        step("edge_b", 1919, 1079);
        step("edge_c", 1920, 1079);
        step("edge_d", 1919, 1080);
        step("edge_e", 2047, 1079);
        step("edge_f", 1919, 1000);
        for (int i = 0; i < 100; i++)
            step("edge_r", $urandom_range(2047, 1790), $urandom_range(2047, 990));

        for (int f = 0; f < 8; f++) begin
            key_en    = 1'($urandom_range(1, 0));
            key_color = ($urandom_range(3, 0) == 0) ? 24'h00FF00
                                                    : 24'($urandom_range(NW - 1, 0));
            step("fs_rnd", near_x(), near_y(), 1, 1'($urandom_range(1, 0)),
                 $urandom_range(1900, 0), $urandom_range(1070, 0),
                 $urandom_range(3, 0));
            rand_steps(200, 1);
        end

        key_en = 1'b0;
        step("fs_pre", 0, 0, 1, 1, 300, 200, 0);
        for (int i = 0; i < 6; i++) step("pre_rst", 300 + i, 200);
        do_reset();
        for (int i = 0; i < 4; i++) step("post_rst", 10 + i, 10);
        step("post_rst_old", 300, 200);
        rand_steps(60, 0);
        repeat (4) step("drain", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
